// File: rtl/uart_receive_if.sv
// Receive-side UART bundle: the serial line in, plus the received byte and its status out.
// The receiver uses the slave view; the line driver/consumer uses the master view.
interface uart_receive_if;
  logic       RX;
  logic [7:0] RXDATA;
  logic       RXDONE;
  logic       RXBUSY;
  logic       FERR;
  logic       BREAK;

  // Signalling: RX is a free-running asynchronous level with no handshake.
  // RXDONE is a single-cycle strobe with no ready/back-pressure. RXDATA, FERR
  // and BREAK are valid in the RXDONE cycle and then held until the next RXDONE.
  modport master (
    output RX,
    input  RXDATA, RXDONE, RXBUSY, FERR, BREAK
  );

  modport slave (
    input  RX,
    output RXDATA, RXDONE, RXBUSY, FERR, BREAK
  );
endinterface

// File: rtl/uart_receive.sv
// 8N1 UART receiver, LSB first: two-flop input synchroniser, mid-bit start
// validation, centre sampling from a baud counter, and done/framing/break status.
module uart_receive #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic           CLK,
  input  logic           RESET,
  uart_receive_if.slave  bus,
  output logic [2:0]     state_dbg
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] H_M1 = CW'(H - 1);
  localparam logic [CW-1:0] N_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          done_n;

  logic       rx_m, rx_s;
  logic [7:0] rxdata;
  logic       rxdone, rxbusy, ferr, brk;

  // Both stages reset high so a reset never looks like a start bit.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= bus.RX;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    bit_n   = bit_idx;
    shift_n = shift;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = S_START;
      end
      S_START: begin
        // A start bit that has gone high again by mid-bit is treated as a glitch.
        if (cnt == H_M1) begin
          cnt_n   = '0;
          bit_n   = 3'd0;
          state_n = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == N_M1) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[7:1]};
          bit_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == N_M1) begin
          cnt_n   = '0;
          done_n  = 1'b1;
          state_n = rx_s ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        // A line held low after a bad stop bit must not start a new frame.
        cnt_n = '0;
        if (rx_s) state_n = S_IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rxdata <= 8'h00;
      rxdone <= 1'b0;
      rxbusy <= 1'b0;
      ferr   <= 1'b0;
      brk    <= 1'b0;
    end else begin
      rxdone <= done_n;
      rxbusy <= (state != S_IDLE);
      if (done_n) begin
        rxdata <= shift;
        ferr   <= ~rx_s;
        brk    <= ~rx_s & (shift == 8'h00);
      end
    end
  end

  assign bus.RXDATA = rxdata;
  assign bus.RXDONE = rxdone;
  assign bus.RXBUSY = rxbusy;
  assign bus.FERR   = ferr;
  assign bus.BREAK  = brk;
  assign state_dbg  = state;

endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive at 16 clocks per bit: frame-level expected
// queue with done-cycle prediction, per-cycle output compare, literal spot checks.
module tb_uart_receive;

  localparam int N = 16;
  localparam int H = N / 2;

  logic       CLK;
  logic       RESET;
  logic [2:0] state_dbg;

  uart_receive_if bus();

  uart_receive #(.CLKS_PER_BIT(N)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] done_cyc;
    logic [7:0]  data;
    logic        ferr;
    logic        brk;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;

  logic [7:0] m_data = 8'h00;
  logic       m_ferr = 1'b0;
  logic       m_brk  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // One compare per negedge: RXDONE only when a frame is due, status held otherwise.
  always @(negedge CLK) begin
    exp_t e;
    if (!RESET) begin
      m_data = 8'h00;
      m_ferr = 1'b0;
      m_brk  = 1'b0;
      chk("rst_rxdata", {24'h0, bus.RXDATA}, 32'h0);
      chk("rst_rxdone", {31'h0, bus.RXDONE}, 32'h0);
      chk("rst_rxbusy", {31'h0, bus.RXBUSY}, 32'h0);
      chk("rst_ferr",   {31'h0, bus.FERR},   32'h0);
      chk("rst_break",  {31'h0, bus.BREAK},  32'h0);
    end else begin
      if (bus.RXDONE) begin
        done_cnt++;
        last_done_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("spurious_done", {31'h0, bus.RXDONE}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("done_time", cyc, e.done_cyc);
          m_data = e.data;
          m_ferr = e.ferr;
          m_brk  = e.brk;
        end
      end else if (exp_q.size() > 0 && cyc > int'(exp_q[0].done_cyc)) begin
        chk("missing_done", {31'h0, bus.RXDONE}, 32'h1);
        void'(exp_q.pop_front());
      end
      chk("rxdata", {24'h0, bus.RXDATA}, {24'h0, m_data});
      chk("ferr",   {31'h0, bus.FERR},   {31'h0, m_ferr});
      chk("break",  {31'h0, bus.BREAK},  {31'h0, m_brk});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drives the first nbits slots of a 10-slot frame (start, 8 data LSB first, stop).
  // Only complete frames are expected to produce a RXDONE.
  task automatic drive_frame(input logic [7:0] d, input logic stop, input int nbits,
                             output int p);
    exp_t e;
    p = cyc;
    if (nbits == 10) begin
      e.done_cyc = 32'(p + 3 + H + 9 * N);
      e.data     = d;
      e.ferr     = ~stop;
      e.brk      = ~stop & (d == 8'h00);
      exp_q.push_back(e);
    end
    for (int i = 0; i < nbits; i++) begin
      if (i == 0)      bus.RX = 1'b0;
      else if (i < 9)  bus.RX = d[i-1];
      else             bus.RX = stop;
      wait_cyc(N);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p;
    int dc0;
    logic saw_busy;

    RESET  = 1'b0;
    bus.RX = 1'b1;
    wait_cyc(3);
    chk("reset_state_dbg", {29'h0, state_dbg}, 32'h0);
    RESET = 1'b1;
    wait_cyc(4);

    // Two clean frames, done 155 cycles after the start bit is driven.
    drive_frame(8'h55, 1'b1, 10, p);
    chk("t1_done_latency", last_done_cyc - p, 155);
    chk("t1_data", {24'h0, bus.RXDATA}, 32'h55);
    chk("t1_ferr", {31'h0, bus.FERR}, 32'h0);
    wait_cyc(5);
    drive_frame(8'hA3, 1'b1, 10, p);
    chk("t1b_done_latency", last_done_cyc - p, 155);
    chk("t1b_data", {24'h0, bus.RXDATA}, 32'hA3);
    chk("t1b_break", {31'h0, bus.BREAK}, 32'h0);
    wait_cyc(5);

    // Short low glitch: busy blips, no frame.
    dc0 = done_cnt;
    saw_busy = 1'b0;
    bus.RX = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge CLK);
      saw_busy |= bus.RXBUSY;
      if (i == 4) bus.RX = 1'b1;
    end
    wait_cyc(1);
    chk("t2_busy_pulse", {31'h0, saw_busy}, 32'h1);
    chk("t2_busy_end", {31'h0, bus.RXBUSY}, 32'h0);
    chk("t2_no_done", done_cnt - dc0, 0);
    chk("t2_data_held", {24'h0, bus.RXDATA}, 32'hA3);

    // Bad stop bit: line still low after the stop sample keeps the receiver busy.
    drive_frame(8'h3C, 1'b0, 10, p);
    chk("t3_wait_busy", {31'h0, bus.RXBUSY}, 32'h1);
    bus.RX = 1'b1;
    chk("t3_data", {24'h0, bus.RXDATA}, 32'h3C);
    chk("t3_ferr", {31'h0, bus.FERR}, 32'h1);
    chk("t3_break", {31'h0, bus.BREAK}, 32'h0);
    wait_cyc(10);
    chk("t3_idle", {31'h0, bus.RXBUSY}, 32'h0);
    drive_frame(8'h5A, 1'b1, 10, p);
    chk("t3_ferr_clear", {31'h0, bus.FERR}, 32'h0);
    wait_cyc(5);

    // Break: 40 bit times low yields one frame of 0x00 with FERR and BREAK.
    dc0 = done_cnt;
    p = cyc;
    exp_q.push_back('{done_cyc: 32'(p + 3 + H + 9 * N), data: 8'h00, ferr: 1'b1, brk: 1'b1});
    bus.RX = 1'b0;
    wait_cyc(20 * N);
    chk("t4_busy_mid", {31'h0, bus.RXBUSY}, 32'h1);
    wait_cyc(20 * N);
    chk("t4_busy_end", {31'h0, bus.RXBUSY}, 32'h1);
    chk("t4_one_done", done_cnt - dc0, 1);
    chk("t4_data", {24'h0, bus.RXDATA}, 32'h00);
    chk("t4_ferr", {31'h0, bus.FERR}, 32'h1);
    chk("t4_break", {31'h0, bus.BREAK}, 32'h1);
    bus.RX = 1'b1;
    wait_cyc(10);
    chk("t4_idle", {31'h0, bus.RXBUSY}, 32'h0);

    // Back-to-back frames with no idle gap.
    dc0 = done_cnt;
    drive_frame(8'hC5, 1'b1, 10, p);
    chk("t5_first", {24'h0, bus.RXDATA}, 32'hC5);
    drive_frame(8'h0E, 1'b1, 10, p);
    chk("t5_second", {24'h0, bus.RXDATA}, 32'h0E);
    chk("t5_two_done", done_cnt - dc0, 2);
    wait_cyc(5);

    // Reset in the middle of data bit 4, then a clean 0x81.
    dc0 = done_cnt;
    drive_frame(8'h0F, 1'b1, 5, p);
    bus.RX = 1'b1;
    wait_cyc(4);
    chk("t6_busy_before", {31'h0, bus.RXBUSY}, 32'h1);
    RESET = 1'b0;
    #1;
    chk("t6_async_busy", {31'h0, bus.RXBUSY}, 32'h0);
    chk("t6_async_data", {24'h0, bus.RXDATA}, 32'h00);
    wait_cyc(3);
    RESET = 1'b1;
    wait_cyc(N * 12);
    chk("t6_no_done", done_cnt - dc0, 0);
    drive_frame(8'h81, 1'b1, 10, p);
    chk("t6_data", {24'h0, bus.RXDATA}, 32'h81);

    wait_cyc(30);
    chk("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receive.md
# uart_receive

Serial-to-parallel UART receiver, 8N1, LSB first. It is the receive-side counterpart of the transmit block in the uart_modules tree. The serial input is synchronized to CLK and the start bit is validated at mid-bit. Each bit is sampled at its centre using an internal baud counter. A completed byte is presented with a one-cycle done pulse plus framing-error and break status. It sits between the board RX pin and the UART control/FIFO logic.

## Interface
- CLKS_PER_BIT, 434, CLK cycles per serial bit (50 MHz / 115200). Minimum legal value 4. Counter width is $clog2(CLKS_PER_BIT).
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  reset, asynchronous, active-low.
- RX  in  1  asynchronous serial line, idle high.
- RXDATA  out  8  last received byte; held until the next frame completes.
- RXDONE  out  1  one-cycle pulse marking the end of a frame; RXDATA, FERR and BREAK are valid in that same cycle.
- RXBUSY  out  1  high while a frame is in progress (any state except IDLE).
- FERR  out  1  framing error of the last frame (stop bit sampled 0); held until the next RXDONE.
- BREAK  out  1  break on the last frame (all data bits 0 and stop bit 0); held until the next RXDONE.

## Operation
- Synchronizer: two flip-flops on RX, both reset to 1. All decisions use the second stage, rx_s. Let H = CLKS_PER_BIT/2 (integer division) and N = CLKS_PER_BIT.
- IDLE:
  - On rx_s==0, go to START with cnt=0.
  - Otherwise cnt=0.
- START: cnt increments each cycle. When cnt==H-1, sample rx_s:
  - rx_s==0: go to DATA with cnt=0 and bit index 0.
  - rx_s==1: go to IDLE. This is glitch reject; no RXDONE and no status change.
- DATA: when cnt==N-1, do all of the following:
  - Shift rx_s into bit 7 of the shift register (shift right, so LSB is received first).
  - Set cnt=0 and increment the bit index.
  - After the 8th sample, go to STOP.
- STOP: when cnt==N-1, sample rx_s and do all of the following:
  - Load RXDATA from the shift register (loaded even when the frame has a framing error).
  - Pulse RXDONE.
  - Set FERR = ~rx_s.
  - Set BREAK = ~rx_s & (shift==0).
  - Next state: IDLE if rx_s==1, else WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then go to IDLE. This prevents a held-low line from retriggering frames. RXBUSY stays high.
- States: IDLE, START, DATA, STOP, WAIT_IDLE (encoding is free). Any undefined encoding goes to IDLE.
- No receive-side flow control. A new frame overwrites RXDATA, FERR and BREAK at its RXDONE. The consumer must capture RXDATA on RXDONE.

## Timing
- Reset values (also applied on reset mid-frame, taking effect immediately and asynchronously):
  - State IDLE, cnt 0, shift register 0x00.
  - Both synchronizer flip-flops 1.
  - RXDATA 0x00, RXDONE 0, RXBUSY 0, FERR 0, BREAK 0.
- Let t0 be the rising edge at which the state enters START. This is the 3rd CLK edge after RX falls, given setup is met.
- Start validation occurs at edge t0+H.
- Data bit k (k=0..7) is sampled at edge t0+H+(k+1)·N.
- The stop bit is sampled at edge t0+H+9·N. RXDONE is high for exactly the one cycle following that edge.
- RXBUSY rises one cycle after t0 (registered) and falls one cycle after the return to IDLE.
- Back-to-back frames: after a valid stop bit the block is in IDLE, so a start edge arriving N-H cycles after the stop sample is accepted.
- A start edge arriving during WAIT_IDLE is ignored until the line has been high for at least one cycle.
- Bit-period tolerance: ±(H-1)/(9.5·N) relative baud mismatch.

## Test plan
- N=16. Send 0x55 with a valid stop bit, then send 0xA3. Required: RXDONE pulses at t0+8+144 for each frame; RXDATA = 0x55 then 0xA3; FERR=0; BREAK=0.
- N=16. Drive RX low for 5 cycles, then high. Required: RXBUSY pulses briefly; no RXDONE; RXDATA, FERR and BREAK unchanged.
- N=16. Send 0x3C with stop bit 0, then the line returns high. Required: RXDONE pulses; RXDATA=0x3C; FERR=1; BREAK=0; WAIT_IDLE is visited; the next valid frame clears FERR.
- N=16. Hold RX low for 40 bit times, then release. Required: exactly one RXDONE; RXDATA=0x00; FERR=1; BREAK=1; RXBUSY stays high until the line is high again.
- N=16. Send two frames with no idle gap (stop bit immediately followed by a start bit). Required: both bytes are received correctly with two RXDONE pulses.
- Assert RESET during data bit 4, release it, then send 0x81. Required: all outputs are at their reset values during reset; no spurious RXDONE; the next frame yields RXDATA=0x81.
